simd_lane_alu: RTL and testbench
================================

# simd_lane_alu

Parametrised multi-cycle SIMD ALU for the user domain. It splits a `DataWidth` word into `NumLanes` lanes of `LaneWidth` bits and performs per-lane add, subtract, multiply, multiply-high and multiply-accumulate. Requests and responses use valid/ready handshakes. Multiplies are serialised through one shared lane multiplier, and per-lane accumulators persist between requests. The block sits behind the user-domain register interface and replaces the fixed 4×8-bit combinational datapath.

## Interface
- `DataWidth`, default 32: operand/result width.
- `LaneWidth`, default 8: lane width. Must divide `DataWidth`. Legal values are 8, 16 and 32. `NumLanes = DataWidth/LaneWidth`.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, synchronous and active-low. One clock; all state is sampled on the rising edge of `clk_i`.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request ready.
- `func_i` in 3: operation select.
- `signed_i` in 1: lanes are two's complement when set.
- `a_i`, `b_i` in `DataWidth`: operands.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response ready.
- `result_o` out `DataWidth`: lane results; lane i occupies bits `[LaneWidth*i +: LaneWidth]`.
- `err_o` out 1: illegal `func_i`. Valid only with `rsp_valid_o`.

## Operation
- `func_i` encoding:
  - 0 ADD: a+b.
  - 1 SUB: a−b.
  - 2 MUL: low `LaneWidth` bits of a*b.
  - 3 MULH: high `LaneWidth` bits of the 2·`LaneWidth` product; signedness per `signed_i`.
  - 4 MAC: acc[i] += low(a*b); result = updated acc.
  - 5 CLR: acc[i] = 0; result = 0.
  - 6, 7: illegal. Result 0, `err_o`=1, accumulators unchanged.
- Handshake: a request is accepted when `req_valid_i && req_ready_o`. `a_i`, `b_i`, `func_i` and `signed_i` are captured at acceptance; later changes are ignored.
- FSM states:
  - IDLE: `req_ready_o`=1.
  - On accept of ADD/SUB/CLR/illegal: IDLE→RESP.
  - On accept of MUL/MULH/MAC: IDLE→EXEC, lane counter = 0.
  - EXEC: processes one lane per cycle through a single `LaneWidth`×`LaneWidth` multiplier and writes that lane of the result register (MAC also writes acc[i]). After lane `NumLanes`−1, EXEC→RESP.
  - RESP: `rsp_valid_o`=1. On `rsp_ready_i`, RESP→IDLE.
- `req_ready_o`=0 in EXEC and RESP. There is no accept in the same cycle as a response handshake.
- Arithmetic: per lane, carries never cross lane boundaries. Without saturation, results wrap modulo 2^`LaneWidth`.
- Accumulators are `NumLanes`×`LaneWidth` bits. They survive between requests and are cleared only by CLR or reset.

## Timing
- Reset values: `req_ready_o`=1 (IDLE), `rsp_valid_o`=0, `result_o`=0, `err_o`=0, accumulators 0, lane counter 0.
- Request accepted in cycle 0:
  - ADD/SUB/CLR/illegal: `rsp_valid_o` first high in cycle 1.
  - MUL/MULH/MAC: lane i is computed in cycle i+1; `rsp_valid_o` first high in cycle `NumLanes`+1.
- `LaneWidth`=`DataWidth`: a single EXEC cycle; multiply latency is 2.
- Under backpressure, `result_o` and `err_o` hold stable while `rsp_valid_o && !rsp_ready_i`.
- Reset asserted in any state, including mid-EXEC: on the next edge the FSM returns to IDLE, the response and accumulators are discarded or cleared, and outputs take their reset values.
- Throughput: ADD-class one op per 2 cycles; multiply-class one op per `NumLanes`+2 cycles, with `rsp_ready_i` held high.

## Configuration
- `SIMD_LANE_ALU_SAT_EN` defined: ADD, SUB, MUL and MAC saturate per lane.
  - `signed_i`=1 clamps to [−2^(L−1), 2^(L−1)−1].
  - `signed_i`=0 clamps to [0, 2^L−1].
  - The MAC clamp applies to the stored accumulator. MULH is unaffected.
- Not defined: all operations wrap, and no saturation logic is instantiated.

## Test plan
- Default params, no SAT, ADD unsigned, a=0x7F01FF10, b=0x01010120 → `result_o`=0x80020030 in cycle 1, `err_o`=0. With SAT enabled: unsigned → 0x8002FF30; signed → 0x7F020030.
- MUL unsigned, a=0x03021010, b=0x04051011 → 0x0C0A0010, `rsp_valid_o` first high in cycle 5. MULH with the same operands → 0x00000101.
- CLR, then MAC a=0x01020304, b=0x01010101 → 0x01020304. Repeat the MAC → 0x02040608. CLR → 0x00000000.
- ADD response with `rsp_ready_i` low for 3 cycles → `result_o` stable, `req_ready_o`=0, and a concurrent `req_valid_i` is not accepted until the cycle after the response handshake.
- MAC accepted in cycle 0, `rst_ni` low in cycle 2 → cycle 3 shows `rsp_valid_o`=0 and `req_ready_o`=1. A following MAC with a=b=0x01010101 returns 0x01010101 (accumulators cleared).
- `func_i`=7, a=b=0xFFFFFFFF → cycle 1: `rsp_valid_o`=1, `err_o`=1, `result_o`=0, accumulators unchanged.

Source files
------------

// File: rtl/simd_lane_alu_if.sv
// Request/response bundle for simd_lane_alu.
// Master drives requests and response ready; slave is the ALU.
interface simd_lane_alu_if #(
  parameter int DataWidth = 32
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [2:0]           func_i;
  logic                 signed_i;
  logic [DataWidth-1:0] a_i;
  logic [DataWidth-1:0] b_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [DataWidth-1:0] result_o;
  logic                 err_o;

  modport master (
    output req_valid_i, func_i, signed_i, a_i, b_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, result_o, err_o
  );

  modport slave (
    input  req_valid_i, func_i, signed_i, a_i, b_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, result_o, err_o
  );
endinterface

// File: rtl/simd_lane_alu.sv
// Multi-cycle SIMD lane ALU: add/sub in one step, multiplies one lane per cycle.
// Optional per-lane saturation is enabled by defining SIMD_LANE_ALU_SAT_EN.
module simd_lane_alu #(
  parameter int DataWidth = 32,
  parameter int LaneWidth = 8
) (
  input logic            clk_i,
  input logic            rst_ni,
  simd_lane_alu_if.slave io
);
  localparam int L  = LaneWidth;
  localparam int NL = DataWidth / LaneWidth;
  localparam int W  = 2 * L + 2;
  localparam int CW = (NL > 1) ? $clog2(NL) : 1;

  typedef logic [NL-1:0][L-1:0] lanes_t;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

`ifdef SIMD_LANE_ALU_SAT_EN
  localparam logic signed [W-1:0] SMAX = {{(W-L+1){1'b0}}, {(L-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = ~SMAX;
  localparam logic signed [W-1:0] UMAX = {{(W-L){1'b0}}, {L{1'b1}}};
`endif

  function automatic logic signed [W-1:0] ext(logic [L-1:0] v, logic s);
    ext = {{(W-L){s & v[L-1]}}, v};
  endfunction

  // Reduce an exact wide lane value to L bits (clamp or wrap).
  function automatic logic [L-1:0] fit(logic signed [W-1:0] v, logic s);
`ifdef SIMD_LANE_ALU_SAT_EN
    if (s) begin
      if (v > SMAX)      fit = SMAX[L-1:0];
      else if (v < SMIN) fit = SMIN[L-1:0];
      else               fit = v[L-1:0];
    end else begin
      if (v < 0)         fit = '0;
      else if (v > UMAX) fit = '1;
      else               fit = v[L-1:0];
    end
`else
    logic unused_bits;
    unused_bits = ^{v[W-1:L], s};
    fit = v[L-1:0];
`endif
  endfunction

  state_e         state_q, state_d;
  logic [CW-1:0]  lane_q, lane_d;
  logic [2:0]     func_q, func_d;
  logic           sgn_q, sgn_d;
  lanes_t         a_q, a_d, b_q, b_d;
  lanes_t         res_q, res_d, acc_q, acc_d;
  logic           err_q, err_d;
  logic           ready_q, ready_d;
  logic           valid_q, valid_d;

  lanes_t                ia, ib;
  logic signed [L:0]     ma, mb;
  logic signed [W-1:0]   prod;
  logic [L-1:0]          acc_new;

  assign ia = io.a_i;
  assign ib = io.b_i;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    func_d  = func_q;
    sgn_d   = sgn_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    acc_d   = acc_q;
    err_d   = err_q;
    ready_d = ready_q;
    valid_d = valid_q;
    ma      = {sgn_q & a_q[lane_q][L-1], a_q[lane_q]};
    mb      = {sgn_q & b_q[lane_q][L-1], b_q[lane_q]};
    prod    = W'(ma) * W'(mb);
    acc_new = fit(ext(acc_q[lane_q], sgn_q) + prod, sgn_q);
    unique case (state_q)
      IDLE: begin
        if (io.req_valid_i) begin
          func_d  = io.func_i;
          sgn_d   = io.signed_i;
          a_d     = ia;
          b_d     = ib;
          res_d   = '0;
          err_d   = 1'b0;
          ready_d = 1'b0;
          state_d = RESP;
          valid_d = 1'b1;
          unique case (io.func_i)
            3'd0, 3'd1: begin
              for (int i = 0; i < NL; i++) begin
                res_d[i] = (io.func_i == 3'd0)
                  ? fit(ext(ia[i], io.signed_i) + ext(ib[i], io.signed_i),
                        io.signed_i)
                  : fit(ext(ia[i], io.signed_i) - ext(ib[i], io.signed_i),
                        io.signed_i);
              end
            end
            3'd2, 3'd3, 3'd4: begin
              state_d = EXEC;
              valid_d = 1'b0;
              lane_d  = '0;
            end
            3'd5: acc_d = '0;
            default: err_d = 1'b1;
          endcase
        end
      end
      EXEC: begin
        unique case (func_q)
          3'd2: res_d[lane_q] = fit(prod, sgn_q);
          3'd3: res_d[lane_q] = prod[2*L-1:L];
          default: begin
            acc_d[lane_q] = acc_new;
            res_d[lane_q] = acc_new;
          end
        endcase
        if (lane_q == CW'(NL - 1)) begin
          lane_d  = '0;
          state_d = RESP;
          valid_d = 1'b1;
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      default: begin
        if (io.rsp_ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      lane_q  <= '0;
      func_q  <= '0;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      func_q  <= func_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign io.req_ready_o = ready_q;
  assign io.rsp_valid_o = valid_q;
  assign io.result_o    = res_q;
  assign io.err_o       = err_q;
endmodule

// File: tb/tb_simd_lane_alu.sv
// Self-checking bench for simd_lane_alu (default 32-bit, 4x8-bit lanes).
// Reference model works on integer lane values with plain arithmetic.
module tb_simd_lane_alu;
  localparam int LW = 8;
  localparam int NL = 4;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   failures = 0;
  longint macc [NL];

  simd_lane_alu_if #(.DataWidth(32)) io ();

  simd_lane_alu #(.DataWidth(32), .LaneWidth(LW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .io     (io.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(longint v, bit s);
    return (s && v >= (64'sd1 <<< (LW - 1))) ? v - (64'sd1 <<< LW) : v;
  endfunction

  function automatic longint fitm(longint v, bit s);
    longint lo, hi;
    lo = s ? -(64'sd1 <<< (LW - 1)) : 0;
    hi = s ? (64'sd1 <<< (LW - 1)) - 1 : (64'sd1 <<< LW) - 1;
`ifdef SIMD_LANE_ALU_SAT_EN
    if (v < lo) v = lo;
    if (v > hi) v = hi;
`else
    if (lo > hi) v = 0;
`endif
    return v & ((64'sd1 <<< LW) - 1);
  endfunction

  task automatic model_op(input logic [2:0] f, input bit s,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output bit e);
    longint av, bv, v;
    r = '0;
    e = (f > 3'd5);
    for (int i = 0; i < NL; i++) begin
      av = sx(longint'(a[LW*i +: LW]), s);
      bv = sx(longint'(b[LW*i +: LW]), s);
      v  = 0;
      case (f)
        3'd0: v = fitm(av + bv, s);
        3'd1: v = fitm(av - bv, s);
        3'd2: v = fitm(av * bv, s);
        3'd3: v = ((av * bv) >>> LW) & ((64'sd1 <<< LW) - 1);
        3'd4: begin
          macc[i] = fitm(sx(macc[i], s) + av * bv, s);
          v = macc[i];
        end
        3'd5: macc[i] = 0;
        default: v = 0;
      endcase
      r[LW*i +: LW] = v[LW-1:0];
    end
  endtask

  task automatic run(input logic [2:0] f, input bit s,
                     input logic [31:0] a, input logic [31:0] b,
                     input int bp, input bit poke,
                     output logic [31:0] got);
    logic [31:0] er;
    bit ee;
    int n, lat;
    model_op(f, s, a, b, er, ee);
    lat = (f >= 3'd2 && f <= 3'd4) ? NL + 1 : 1;
    @(negedge clk);
    io.req_valid_i = 1'b1;
    io.func_i = f;
    io.signed_i = s;
    io.a_i = a;
    io.b_i = b;
    n = 0;
    while (!io.req_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", io.req_ready_o, 1);
    @(posedge clk);
    #1;
    io.req_valid_i = poke;
    io.func_i = 3'($urandom);
    io.signed_i = 1'($urandom);
    io.a_i = $urandom;
    io.b_i = $urandom;
    @(negedge clk);
    n = 1;
    while (!io.rsp_valid_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_latency", 64'(n), 64'(lat));
    chk("result", io.result_o, er);
    chk("err", io.err_o, ee);
    chk("busy_ready", io.req_ready_o, 0);
    got = io.result_o;
    repeat (bp) begin
      @(negedge clk);
      chk("hold_valid", io.rsp_valid_o, 1);
      chk("hold_result", io.result_o, er);
      chk("hold_err", io.err_o, ee);
      chk("hold_ready", io.req_ready_o, 0);
    end
    io.rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    io.rsp_ready_i = 1'b0;
    @(negedge clk);
    chk("post_ready", io.req_ready_o, 1);
    chk("post_valid", io.rsp_valid_o, 0);
    io.req_valid_i = 1'b0;
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] er;
    bit ee;
    int n;
    io.req_valid_i = 1'b0;
    io.func_i = '0;
    io.signed_i = 1'b0;
    io.a_i = '0;
    io.b_i = '0;
    io.rsp_ready_i = 1'b0;
    for (int i = 0; i < NL; i++) macc[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", io.req_ready_o, 1);
    chk("rst_valid", io.rsp_valid_o, 0);
    chk("rst_result", io.result_o, 0);
    chk("rst_err", io.err_o, 0);
    rst_ni = 1'b1;

    run(3'd0, 1'b0, 32'h7F01FF10, 32'h01010120, 0, 1'b0, got);
`ifdef SIMD_LANE_ALU_SAT_EN
    chk("plan_add_u", got, 32'h8002FF30);
    run(3'd0, 1'b1, 32'h7F01FF10, 32'h01010120, 0, 1'b0, got);
    chk("plan_add_s", got, 32'h7F020030);
`else
    chk("plan_add_u", got, 32'h80020030);
`endif
    run(3'd2, 1'b0, 32'h03021010, 32'h04051011, 0, 1'b0, got);
    chk("plan_mul", got, 32'h0C0A0010);
    run(3'd3, 1'b0, 32'h03021010, 32'h04051011, 0, 1'b0, got);
    chk("plan_mulh", got, 32'h00000101);
    run(3'd5, 1'b0, 32'h0, 32'h0, 0, 1'b0, got);
    run(3'd4, 1'b0, 32'h01020304, 32'h01010101, 0, 1'b0, got);
    chk("plan_mac1", got, 32'h01020304);
    run(3'd4, 1'b0, 32'h01020304, 32'h01010101, 0, 1'b0, got);
    chk("plan_mac2", got, 32'h02040608);
    run(3'd5, 1'b0, 32'h0, 32'h0, 0, 1'b0, got);
    chk("plan_clr", got, 32'h0);

    run(3'd0, 1'b0, 32'h11223344, 32'h01010101, 3, 1'b1, got);

    run(3'd4, 1'b0, 32'h05060708, 32'h02020202, 0, 1'b0, got);
    @(negedge clk);
    io.req_valid_i = 1'b1;
    io.func_i = 3'd4;
    io.signed_i = 1'b0;
    io.a_i = 32'h09090909;
    io.b_i = 32'h03030303;
    @(posedge clk);
    #1;
    io.req_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    chk("midrst_valid", io.rsp_valid_o, 0);
    chk("midrst_ready", io.req_ready_o, 1);
    chk("midrst_result", io.result_o, 0);
    rst_ni = 1'b1;
    for (int i = 0; i < NL; i++) macc[i] = 0;
    run(3'd4, 1'b0, 32'h01010101, 32'h01010101, 0, 1'b0, got);
    chk("midrst_mac", got, 32'h01010101);

    run(3'd7, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, got);
    chk("illegal_res", got, 32'h0);
    run(3'd4, 1'b0, 32'h0, 32'h0, 0, 1'b0, got);
    chk("illegal_keep_acc", got, 32'h01010101);

    for (int k = 0; k < 60; k++) begin
      run(3'($urandom_range(0, 7)), 1'($urandom), $urandom, $urandom,
          int'($urandom_range(0, 2)), 1'b0, got);
    end

    model_op(3'd4, 1'b0, 32'h0, 32'h0, er, ee);
    run(3'd4, 1'b0, 32'h0, 32'h0, 0, 1'b0, got);
    n = 0;
    chk("final_acc", got, er);
    chk("final_err", 64'(ee), 64'(n));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
